edp_md_seq: RTL and testbench
=============================

// Module: edp_md_seq
// PURPOSE
//  Step sequencer for iterative multiply and divide on the EBOX data path.
//  - Owns the AD function, AR/ARX load and MQ shift-mode controls while a MUL/DIV runs.
//  - Sequences Booth radix-2 multiply or non-restoring divide for a programmable step count.
//  - Hands the EDP back to microcode control (busy low) when finished.
// PARAMETERS
//  MAX_STEPS  36  largest legal step count (72 for double-word ops)
//  CW         7   step counter width; must satisfy 2**CW > MAX_STEPS
// PORTS
//  eboxClk    in   1      EBOX clock; all state changes on rising edge
//  eboxResetN in   1      asynchronous, active-low reset
//  start      in   1      one-cycle request; sampled only in IDLE
//  opDiv      in   1      0=multiply, 1=divide; sampled with start
//  nSteps     in   CW     step count; sampled with start
//  abort      in   1      synchronous cancel (page fail / interrupt)
//  mq35       in   1      EDP_MQ[35], current multiplier LSB
//  adSign     in   1      sign of the current AD result (EDP_ADcarry[-2])
//  brLoad     out  1      copy AR->BR and ARX->BRX (SETUP only)
//  adOp       out  2      00=PASS (A), 01=ADD (A+B), 10=SUB (A-B); 11 never driven
//  arLoad     out  1      load AR from the shifted AD
//  arxLoad    out  1      load ARX from the shifted AD/ADX
//  mqSel      out  2      USR code: 00 LOAD, 01 SHL, 10 SHR, 11 HOLD
//  quoBit     out  1      quotient bit shifted into MQ[35] on divide steps
//  busy       out  1      sequencer owns the EDP controls
//  done       out  1      one-cycle completion pulse
//  divOvf     out  1      sticky divide-overflow flag; cleared by the next accepted start
// BEHAVIOUR
//  Reset (async, eboxResetN=0) and IDLE output values:
//  - State=IDLE; counter and qPrev cleared; divOvf=0.
//  - All outputs 0, except mqSel=11 (HOLD).
//  States: IDLE -> SETUP -> STEP -> [FIXUP] -> DONE -> IDLE.
//  - IDLE:  start=1 latches opDiv and nSteps and clears divOvf.
//           Next state is SETUP, or DONE if nSteps==0.
//           nSteps>MAX_STEPS is clamped to MAX_STEPS.
//  - SETUP: 1 cycle. brLoad=1, busy=1, qPrev<=0, cnt<=nSteps.
//  - STEP:  busy=1, arLoad=arxLoad=1, cnt decrements each cycle.
//           Leave when cnt==1: MUL goes to DONE, DIV goes to FIXUP.
//    MUL:   mqSel=10 (SHR). adOp from {mq35,qPrev}: 10->SUB, 01->ADD, 00/11->PASS.
//           qPrev<=mq35 each step.
//    DIV:   mqSel=01 (SHL). First step adOp=SUB.
//           Later steps: ADD if the previous step's sampled sign=1, else SUB.
//           quoBit=~adSign, a combinational path within the cycle.
//           Overflow: if adSign=0 at the end of step 1, set divOvf=1 and go to DONE;
//           no further steps, no FIXUP.
//  - FIXUP: 1 cycle, busy=1, mqSel=11.
//           If the last sampled sign=1: adOp=ADD, arLoad=1 (restore remainder).
//           Otherwise adOp=PASS with no loads.
//  - DONE:  1 cycle. done=1, busy=1, all loads 0, mqSel=11. Next state is IDLE.
//  Latency (start at edge 0):
//  - MUL: done high in cycle nSteps+2.
//  - DIV: done high in cycle nSteps+3.
//  - Overflow: done high in cycle 3.
//  Boundary rules:
//  - start while not IDLE is ignored; divOvf is unchanged.
//  - abort in any non-IDLE state -> IDLE next edge.
//    No done pulse is emitted for an aborted operation.
//    Loads are deasserted in the abort cycle; divOvf is unchanged.
//  - abort and start in the same IDLE cycle: abort wins, start is dropped.
//  - eboxResetN low mid-operation: outputs take reset values immediately (async).
//  - Counter never wraps. nSteps==1 gives exactly one STEP cycle.
// TESTING
//  1. Reset mid-STEP, eboxResetN low -> same-cycle busy=0, mqSel=11, arLoad=0, divOvf=0.
//  2. MUL nSteps=4, mq35 sequence 1,1,0,1 -> adOp SUB,PASS,ADD,SUB; done at cycle 6.
//  3. DIV nSteps=3, adSign 1,0,1 -> adOp SUB,ADD,SUB; quoBit 0,1,0;
//     FIXUP adOp=ADD; done at cycle 6; divOvf=0.
//  4. DIV with adSign=0 on step 1 -> divOvf=1, done at cycle 3, exactly one STEP cycle.
//  5. Abort during the 2nd STEP of a 10-step MUL -> IDLE next edge, no done pulse.
//     Next start proceeds normally.
//  6. start asserted while busy -> ignored. nSteps=0 -> done at cycle 1, no loads.
//     nSteps=40 -> clamped to 36 steps.

Source files
------------

// File: rtl/edp_md_seq_if.sv
// rtl/edp_md_seq_if.sv - control bundle between EBOX microcode and the MUL/DIV step sequencer
//
// Purpose: groups the request, data-path status and data-path control lines of
// edp_md_seq so they can be passed as one port.
// Signals:
//   start, opDiv, nSteps, abort   request side (microcode -> sequencer)
//   mq35, adSign                  data-path status (EDP -> sequencer)
//   brLoad, adOp, arLoad, arxLoad,
//   mqSel, quoBit                 data-path controls (sequencer -> EDP)
//   busy, done, divOvf            status (sequencer -> microcode)
// Modports: master = microcode/EDP side, slave = sequencer.

interface edp_md_seq_if #(
  parameter int CW = 7
);
  logic          start;
  logic          opDiv;
  logic [CW-1:0] nSteps;
  logic          abort;
  logic          mq35;
  logic          adSign;
  logic          brLoad;
  logic [1:0]    adOp;
  logic          arLoad;
  logic          arxLoad;
  logic [1:0]    mqSel;
  logic          quoBit;
  logic          busy;
  logic          done;
  logic          divOvf;

  modport master (
    output start, opDiv, nSteps, abort, mq35, adSign,
    input  brLoad, adOp, arLoad, arxLoad, mqSel, quoBit, busy, done, divOvf
  );

  modport slave (
    input  start, opDiv, nSteps, abort, mq35, adSign,
    output brLoad, adOp, arLoad, arxLoad, mqSel, quoBit, busy, done, divOvf
  );
endinterface

// File: rtl/edp_md_seq.sv
// rtl/edp_md_seq.sv - Booth multiply / non-restoring divide step sequencer for the EBOX data path
//
// Purpose: while a MUL/DIV runs, owns the AD function, AR/ARX loads and MQ
// shift mode, stepping a programmable number of times, then returns the EDP
// to microcode (busy low).
// Ports:
//   eboxClk     EBOX clock, rising edge
//   eboxResetN  asynchronous active-low reset
//   bus         edp_md_seq_if.slave (request, EDP status, EDP controls, status)

module edp_md_seq #(
  parameter int MAX_STEPS = 36,
  parameter int CW        = 7
) (
  input  logic        eboxClk,
  input  logic        eboxResetN,
  edp_md_seq_if.slave bus
);

  localparam logic [1:0] AD_PASS = 2'b00;
  localparam logic [1:0] AD_ADD  = 2'b01;
  localparam logic [1:0] AD_SUB  = 2'b10;
  localparam logic [1:0] MQ_SHL  = 2'b01;
  localparam logic [1:0] MQ_SHR  = 2'b10;
  localparam logic [1:0] MQ_HOLD = 2'b11;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STEP, S_FIXUP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] steps_q, steps_d;
  logic          op_div_q, op_div_d;
  // MUL: previous multiplier bit (Booth pair). DIV: previous step's AD sign.
  logic          q_prev_q, q_prev_d;
  logic          div_ovf_q, div_ovf_d;

  logic       br_load, ar_load, arx_load, quo_bit, busy, done;
  logic [1:0] ad_op, mq_sel;

  always_ff @(posedge eboxClk or negedge eboxResetN) begin
    if (!eboxResetN) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      steps_q   <= '0;
      op_div_q  <= 1'b0;
      q_prev_q  <= 1'b0;
      div_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      steps_q   <= steps_d;
      op_div_q  <= op_div_d;
      q_prev_q  <= q_prev_d;
      div_ovf_q <= div_ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    steps_d   = steps_q;
    op_div_d  = op_div_q;
    q_prev_d  = q_prev_q;
    div_ovf_d = div_ovf_q;
    br_load   = 1'b0;
    ar_load   = 1'b0;
    arx_load  = 1'b0;
    quo_bit   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    ad_op     = AD_PASS;
    mq_sel    = MQ_HOLD;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          op_div_d  = bus.opDiv;
          steps_d   = (bus.nSteps > MAX_C) ? MAX_C : bus.nSteps;
          div_ovf_d = 1'b0;
          state_d   = (bus.nSteps == '0) ? S_DONE : S_SETUP;
        end
      end
      S_SETUP: begin
        busy     = 1'b1;
        br_load  = 1'b1;
        q_prev_d = 1'b0;
        cnt_d    = steps_q;
        state_d  = S_STEP;
      end
      S_STEP: begin
        busy     = 1'b1;
        ar_load  = 1'b1;
        arx_load = 1'b1;
        cnt_d    = cnt_q - 1'b1;
        if (op_div_q) begin
          mq_sel   = MQ_SHL;
          // q_prev_q is cleared in SETUP, so the first step naturally subtracts.
          ad_op    = q_prev_q ? AD_ADD : AD_SUB;
          quo_bit  = ~bus.adSign;
          q_prev_d = bus.adSign;
          // First step still counting from the full load: positive result means overflow.
          if ((cnt_q == steps_q) && !bus.adSign) begin
            div_ovf_d = 1'b1;
            state_d   = S_DONE;
          end else if (cnt_q == 1) begin
            state_d = S_FIXUP;
          end
        end else begin
          mq_sel = MQ_SHR;
          case ({bus.mq35, q_prev_q})
            2'b10:   ad_op = AD_SUB;
            2'b01:   ad_op = AD_ADD;
            default: ad_op = AD_PASS;
          endcase
          q_prev_d = bus.mq35;
          if (cnt_q == 1) state_d = S_DONE;
        end
      end
      S_FIXUP: begin
        busy = 1'b1;
        // Negative final remainder is restored by adding the divisor back.
        if (q_prev_q) begin
          ad_op   = AD_ADD;
          ar_load = 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Cancel: drop every load and the done pulse this cycle, keep the overflow flag.
    if ((state_q != S_IDLE) && bus.abort) begin
      state_d   = S_IDLE;
      div_ovf_d = div_ovf_q;
      br_load   = 1'b0;
      ar_load   = 1'b0;
      arx_load  = 1'b0;
      quo_bit   = 1'b0;
      done      = 1'b0;
      ad_op     = AD_PASS;
      mq_sel    = MQ_HOLD;
    end
  end

  assign bus.brLoad  = br_load;
  assign bus.adOp    = ad_op;
  assign bus.arLoad  = ar_load;
  assign bus.arxLoad = arx_load;
  assign bus.mqSel   = mq_sel;
  assign bus.quoBit  = quo_bit;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.divOvf  = div_ovf_q;

endmodule

// File: tb/tb_edp_md_seq.sv
// tb/tb_edp_md_seq.sv - randomized self-checking bench for edp_md_seq against a trace model

module tb_edp_md_seq;
  localparam int CW   = 7;
  localparam int MAXS = 36;
  localparam logic [1:0] PASS = 2'b00, ADD = 2'b01, SUB = 2'b10;
  localparam logic [1:0] SHL = 2'b01, SHR = 2'b10, HOLD = 2'b11;

  logic eboxClk    = 1'b0;
  logic eboxResetN = 1'b0;

  edp_md_seq_if #(.CW(CW)) bus();

  edp_md_seq #(.MAX_STEPS(MAXS), .CW(CW)) dut (
    .eboxClk   (eboxClk),
    .eboxResetN(eboxResetN),
    .bus       (bus)
  );

  always #5 eboxClk = ~eboxClk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle value of mq35/adSign; cycle 0 is the start cycle, STEP k runs in cycle k+1.
  bit in_bit[0:127];
  logic [10:0] exp_q[$];

  function automatic logic [10:0] vec(bit busy, bit br, logic [1:0] op, bit ar, bit arx,
                                      logic [1:0] mq, bit quo, bit dn, bit ovf);
    return {busy, br, op, ar, arx, mq, quo, dn, ovf};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {bus.busy, bus.brLoad, bus.adOp, bus.arLoad, bus.arxLoad,
            bus.mqSel, bus.quoBit, bus.done, bus.divOvf};
  endfunction

  task automatic rand_inputs();
    for (int i = 0; i < 128; i++) in_bit[i] = 1'($urandom);
  endtask

  // Reference: the expected output trace from cycle 1 through the DONE cycle.
  task automatic build(input bit div, input int n, output bit ovf, output int lat);
    int  ne;
    bit  cur, prv;
    logic [1:0] op;
    ne  = (n > MAXS) ? MAXS : n;
    ovf = 1'b0;
    exp_q.delete();
    if (ne == 0) begin
      exp_q.push_back(vec(1, 0, PASS, 0, 0, HOLD, 0, 1, 0));
      lat = 1;
      return;
    end
    exp_q.push_back(vec(1, 1, PASS, 0, 0, HOLD, 0, 0, 0));
    for (int k = 1; k <= ne; k++) begin
      cur = in_bit[k+1];
      prv = (k == 1) ? 1'b0 : in_bit[k];
      if (!div) begin
        op = (cur && !prv) ? SUB : (!cur && prv) ? ADD : PASS;
        exp_q.push_back(vec(1, 0, op, 1, 1, SHR, 0, 0, 0));
      end else begin
        op = (k == 1) ? SUB : (prv ? ADD : SUB);
        exp_q.push_back(vec(1, 0, op, 1, 1, SHL, !cur, 0, 0));
        if (k == 1 && !cur) begin
          ovf = 1'b1;
          break;
        end
      end
    end
    if (div && !ovf)
      exp_q.push_back(in_bit[ne+1] ? vec(1, 0, ADD, 1, 0, HOLD, 0, 0, 0)
                                   : vec(1, 0, PASS, 0, 0, HOLD, 0, 0, 0));
    exp_q.push_back(vec(1, 0, PASS, 0, 0, HOLD, 0, 1, ovf));
    lat = !div ? ne + 2 : (ovf ? 3 : ne + 3);
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic run_op(input string nm, input bit div, input int n, input int abort_at, input bit noise);
    bit  ovf, fin_ovf;
    int  lat, ab, done_cyc;
    logic [10:0] e;
    build(div, n, ovf, lat);
    ab       = (abort_at > exp_q.size()) ? 0 : abort_at;
    done_cyc = -1;
    fin_ovf  = ovf;
    bus.start  = 1'b1;
    bus.opDiv  = div;
    bus.nSteps = CW'(n);
    bus.abort  = 1'b0;
    bus.mq35   = in_bit[0];
    bus.adSign = in_bit[0];
    @(posedge eboxClk); #1;
    for (int c = 1; c <= exp_q.size(); c++) begin
      bus.mq35   = in_bit[c];
      bus.adSign = in_bit[c];
      bus.start  = noise ? 1'($urandom) : 1'b0;
      bus.opDiv  = 1'($urandom);
      bus.nSteps = CW'($urandom);
      bus.abort  = (c == ab);
      @(negedge eboxClk);
      e = exp_q[c-1];
      if (c == ab) begin
        e = vec(1, 0, PASS, 0, 0, HOLD, 0, 0, e[0]);
        fin_ovf = e[0];
      end
      chk($sformatf("%s n=%0d cyc%0d", nm, n, c), {21'd0, obs_vec()}, {21'd0, e});
      if (bus.done) done_cyc = c;
      @(posedge eboxClk); #1;
      if (c == ab) break;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge eboxClk);
    chk($sformatf("%s idle", nm), {21'd0, obs_vec()},
        {21'd0, vec(0, 0, PASS, 0, 0, HOLD, 0, 0, fin_ovf)});
    chk($sformatf("%s done_cycle", nm), done_cyc, (ab > 0) ? -1 : lat);
    @(posedge eboxClk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.opDiv = 0; bus.nSteps = '0; bus.abort = 0; bus.mq35 = 0; bus.adSign = 0;
    repeat (2) @(posedge eboxClk);
    @(negedge eboxClk);
    chk("reset", {21'd0, obs_vec()}, {21'd0, vec(0, 0, PASS, 0, 0, HOLD, 0, 0, 0)});
    eboxResetN = 1'b1;
    @(posedge eboxClk); #1;

    rand_inputs();
    in_bit[2] = 1; in_bit[3] = 1; in_bit[4] = 0; in_bit[5] = 1;
    run_op("mul4", 0, 4, 0, 0);

    rand_inputs();
    in_bit[2] = 1; in_bit[3] = 0; in_bit[4] = 1;
    run_op("div3", 1, 3, 0, 0);

    rand_inputs();
    in_bit[2] = 0;
    run_op("divovf", 1, 5, 0, 0);

    // abort and start together in IDLE: start dropped, overflow flag kept
    bus.start = 1; bus.abort = 1; bus.opDiv = 0; bus.nSteps = 7'd5;
    @(posedge eboxClk); #1;
    bus.start = 0; bus.abort = 0;
    @(negedge eboxClk);
    chk("abort_start_idle", {21'd0, obs_vec()}, {21'd0, vec(0, 0, PASS, 0, 0, HOLD, 0, 0, 1)});
    @(posedge eboxClk); #1;

    rand_inputs();
    run_op("mul10_abort", 0, 10, 3, 0);
    rand_inputs();
    run_op("after_abort", 0, 3, 0, 0);
    rand_inputs();
    run_op("busy_start", 0, 6, 0, 1);
    rand_inputs();
    run_op("zero", 1, 0, 0, 0);
    rand_inputs();
    run_op("clamp40", 0, 40, 0, 0);

    // asynchronous reset in the middle of a multiply
    rand_inputs();
    bus.start = 1; bus.opDiv = 0; bus.nSteps = 7'd8;
    @(posedge eboxClk); #1;
    bus.start = 0;
    repeat (2) begin @(posedge eboxClk); #1; end
    chk("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    eboxResetN = 1'b0;
    #1;
    chk("async_reset", {28'd0, bus.busy, bus.mqSel, bus.arLoad, bus.divOvf}, {28'd0, 1'b0, HOLD, 1'b0, 1'b0});
    @(negedge eboxClk);
    eboxResetN = 1'b1;
    @(posedge eboxClk); #1;

    for (int i = 0; i < 25; i++) begin
      rand_inputs();
      if (i % 3 == 0) in_bit[2] = 1'b1;
      run_op($sformatf("rnd%0d", i), 1'($urandom), int'($urandom_range(0, 45)),
             ($urandom % 4 == 0) ? int'($urandom_range(1, 45)) : 0, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
